// File: rtl/synapse_accumulator.sv
// rtl/synapse_accumulator.sv - per-neuron synapse table with spike flagging and sequential weighted-sum accumulation
module synapse_accumulator #(
    parameter int NUM_CONN = 8,
    parameter int ADDR_W   = 12,
    parameter int WEIGHT_W = 16,
    localparam int IDX_W   = $clog2(NUM_CONN),
    localparam int ACC_W   = WEIGHT_W + $clog2(NUM_CONN)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_index,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    input  logic                cfg_en,
    input  logic                spike_valid,
    input  logic [ADDR_W-1:0]   spike_addr,
    input  logic                timestep_end,
    output logic [ACC_W-1:0]    sum_out,
    output logic                sum_valid,
    output logic                busy,
    output logic                overrun
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [ADDR_W-1:0]   addr_tab   [NUM_CONN];
    logic [WEIGHT_W-1:0] weight_tab [NUM_CONN];
    logic [NUM_CONN-1:0] en_tab;
    logic [NUM_CONN-1:0] incoming;
    logic [NUM_CONN-1:0] snapshot;
    logic [NUM_CONN-1:0] match;
    logic [1:0]          state;
    logic [IDX_W-1:0]    idx;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    weight_ext;
    logic                cfg_ok;
    logic                accept_ts;
    logic                last_idx;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_CONN; i++) begin
            match[i] = spike_valid && en_tab[i] && (addr_tab[i] == spike_addr);
        end
    end

    assign weight_ext = {{(ACC_W-WEIGHT_W){weight_tab[idx][WEIGHT_W-1]}}, weight_tab[idx]};
    assign acc_next   = snapshot[idx] ? acc + weight_ext : acc;
    assign last_idx   = (idx == IDX_W'(NUM_CONN - 1));
    assign accept_ts  = (state == IDLE) && timestep_end;
    // Writes only land while the table is not being read by an accumulation.
    assign cfg_ok     = cfg_we && (state == IDLE) && !timestep_end &&
                        ({{(32-IDX_W){1'b0}}, cfg_index} < 32'(NUM_CONN));
    assign busy       = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CONN; i++) begin
                addr_tab[i]   <= '0;
                weight_tab[i] <= '0;
            end
            en_tab    <= '0;
            incoming  <= '0;
            snapshot  <= '0;
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            overrun   <= timestep_end && (state != IDLE);

            if (cfg_ok) begin
                addr_tab[cfg_index]   <= cfg_addr;
                weight_tab[cfg_index] <= cfg_weight;
                en_tab[cfg_index]     <= cfg_en;
            end

            // A spike coincident with an accepted timestep_end belongs to the next timestep.
            if (accept_ts) begin
                incoming <= match;
            end else begin
                incoming <= incoming | match;
            end

            case (state)
                IDLE: begin
                    if (timestep_end) begin
                        snapshot <= incoming;
                        acc      <= '0;
                        idx      <= '0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (last_idx) begin
                        sum_out   <= acc_next;
                        sum_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_synapse_accumulator.sv
// tb/tb_synapse_accumulator.sv - scoreboard bench for synapse_accumulator
module tb_synapse_accumulator;

    localparam int NUM_CONN = 8;
    localparam int ADDR_W   = 12;
    localparam int WEIGHT_W = 16;
    localparam int IDX_W    = 3;
    localparam int ACC_W    = 19;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_index;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [WEIGHT_W-1:0] cfg_weight;
    logic                cfg_en;
    logic                spike_valid;
    logic [ADDR_W-1:0]   spike_addr;
    logic                timestep_end;
    logic [ACC_W-1:0]    sum_out;
    logic                sum_valid;
    logic                busy;
    logic                overrun;

    int checks = 0;
    int errors = 0;
    logic [ACC_W-1:0] exp_q[$];

    synapse_accumulator #(
        .NUM_CONN(NUM_CONN),
        .ADDR_W(ADDR_W),
        .WEIGHT_W(WEIGHT_W)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cfg_we(cfg_we),
        .cfg_index(cfg_index),
        .cfg_addr(cfg_addr),
        .cfg_weight(cfg_weight),
        .cfg_en(cfg_en),
        .spike_valid(spike_valid),
        .spike_addr(spike_addr),
        .timestep_end(timestep_end),
        .sum_out(sum_out),
        .sum_valid(sum_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sum_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sum_valid sum_out=%0d required no strobe", $signed(sum_out));
            end else begin
                logic [ACC_W-1:0] e;
                e = exp_q.pop_front();
                if (sum_out !== e) begin
                    errors++;
                    $display("FAIL sum_out got=%0d exp=%0d", $signed(sum_out), $signed(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic write_entry(input int i, input int a, input int w, input bit en);
        cfg_we     = 1'b1;
        cfg_index  = IDX_W'(i);
        cfg_addr   = ADDR_W'(a);
        cfg_weight = WEIGHT_W'(w);
        cfg_en     = en;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic spike(input int a);
        spike_valid = 1'b1;
        spike_addr  = ADDR_W'(a);
        tick();
        spike_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout busy=%0d exp=0", busy);
        end
        tick();
    endtask

    task automatic run_ts(input int exp_sum);
        exp_q.push_back(ACC_W'(exp_sum));
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        wait_idle();
    endtask

    initial begin
        int lat;
        int busy_cnt;
        reset_n = 1'b0; cfg_we = 1'b0; cfg_index = '0; cfg_addr = '0; cfg_weight = '0;
        cfg_en = 1'b0; spike_valid = 1'b0; spike_addr = '0; timestep_end = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        check("reset_sum_out", int'(sum_out), 0);
        check("reset_sum_valid", int'(sum_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_overrun", int'(overrun), 0);

        // Empty table: latency and busy width
        exp_q.push_back('0);
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        lat = 0;
        busy_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            if (busy) busy_cnt++;
            if (sum_valid && lat == 0) lat = i;
            tick();
        end
        check("latency", lat, 9);
        check("busy_cycles", busy_cnt, 9);

        write_entry(0, 3, 100, 1);
        write_entry(1, 4, -20, 1);
        write_entry(2, 5, 50, 1);
        write_entry(3, 6, 0, 1);
        write_entry(4, 7, 87, 1);
        spike(3); spike(5); spike(7);
        run_ts(237);

        write_entry(1, 4, -20, 0);
        spike(5); spike(5); spike(5); spike(9); spike(4);
        run_ts(50);

        // Spike coincident with timestep_end rolls into the next timestep
        write_entry(1, 4, -20, 1);
        exp_q.push_back('0);
        spike_valid = 1'b1;
        spike_addr  = ADDR_W'(4);
        timestep_end = 1'b1;
        tick();
        spike_valid = 1'b0;
        timestep_end = 1'b0;
        wait_idle();
        run_ts(-20);

        for (int i = 0; i < NUM_CONN; i++) write_entry(i, 1, -32768, 1);
        spike(1);
        exp_q.push_back(ACC_W'(-262144));
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b1;
        cfg_we = 1'b1; cfg_index = '0; cfg_addr = ADDR_W'(1); cfg_weight = WEIGHT_W'(5); cfg_en = 1'b1;
        tick();
        timestep_end = 1'b0;
        cfg_we = 1'b0;
        check("overrun_pulse", int'(overrun), 1);
        tick();
        check("overrun_clear", int'(overrun), 0);
        wait_idle();
        spike(1);
        run_ts(-262144);

        // Reset in the middle of an accumulation
        spike(1);
        timestep_end = 1'b1;
        tick();
        timestep_end = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_sum_out", int'(sum_out), 0);
        check("midreset_sum_valid", int'(sum_valid), 0);
        tick();
        spike(1);
        run_ts(0);

        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
